// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared types and constants for the program loader
package program_loader_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int MAX_LEN = 1 << ADDR_W_DEF;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  // A frame must carry at least one byte and no more than the memory holds.
  function automatic logic len_ok(input int unsigned len, input int unsigned depth);
    return (len != 0) && (len <= depth);
  endfunction

endpackage

// File: rtl/program_loader.sv
// rtl/program_loader.sv - receives a framed program image, writes it to core memory,
// verifies its checksum and releases the core on a good frame
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter logic [DATA_W-1:0] SYNC = SYNC_BYTE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   bytes_loaded
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] sum_q;
  logic [ADDR_W:0]   len_q;
  logic              accept;
  logic              is_sync;
  logic              len_good;
  logic [ADDR_W:0]   cnt_inc;

  assign accept   = in_valid & in_ready;
  assign is_sync  = (in_data == SYNC);
  assign len_good = len_ok(32'(in_data), DEPTH);
  assign cnt_inc  = bytes_loaded + {{ADDR_W{1'b0}}, 1'b1};

  // The single DONE cycle is the only time the loader refuses input.
  assign in_ready  = (state != DONE);
  assign load_done = (state == DONE);
  assign cpu_rst   = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ERR: begin
        if (accept && is_sync) begin
          state_nxt = LEN;
        end
      end
      LEN: begin
        if (accept) begin
          state_nxt = len_good ? DATA : ERR;
        end
      end
      DATA: begin
        if (accept && (cnt_inc == len_q)) begin
          state_nxt = CSUM;
        end
      end
      CSUM: begin
        if (accept) begin
          state_nxt = (in_data == sum_q) ? DONE : ERR;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Write address is the running data-byte count, so bytes land at 0..LEN-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cpu_hold     <= 1'b1;
      load_err     <= 1'b0;
      bytes_loaded <= '0;
      sum_q        <= '0;
      len_q        <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, ERR: begin
          if (accept && is_sync) begin
            cpu_hold     <= 1'b1;
            load_err     <= 1'b0;
            bytes_loaded <= '0;
          end
        end
        LEN: begin
          if (accept) begin
            if (len_good) begin
              len_q <= in_data[ADDR_W:0];
              sum_q <= '0;
            end else begin
              load_err <= 1'b1;
            end
          end
        end
        DATA: begin
          if (accept) begin
            mem_we       <= 1'b1;
            mem_addr     <= bytes_loaded[ADDR_W-1:0];
            mem_wdata    <= in_data;
            sum_q        <= sum_q + in_data;
            bytes_loaded <= cnt_inc;
          end
        end
        CSUM: begin
          if (accept && (in_data != sum_q)) begin
            load_err <= 1'b1;
          end
        end
        DONE: begin
          cpu_hold <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_hold;
  logic       cpu_rst;
  logic       load_done;
  logic       load_err;
  logic [4:0] bytes_loaded;

  int checks = 0;
  int errors = 0;

  logic [3:0] wa_log[$];
  logic [7:0] wd_log[$];
  int done_cnt = 0;
  int rst_cnt = 0;

  logic [7:0] fr[$];
  int base_wr;
  int base_done;
  int base_rst;

  program_loader dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold),
    .cpu_rst(cpu_rst),
    .load_done(load_done),
    .load_err(load_err),
    .bytes_loaded(bytes_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_we) begin
        wa_log.push_back(mem_addr);
        wd_log.push_back(mem_wdata);
      end
      if (load_done) done_cnt++;
      if (cpu_rst) rst_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] f[$], input bit gaps);
    foreach (f[i]) begin
      if (gaps) begin
        repeat ($urandom_range(0, 1)) begin
          @(negedge clk);
          in_valid = 1'b0;
        end
      end
      send_byte(f[i]);
    end
  endtask

  task automatic go_idle(input int cycles);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic mark();
    base_wr   = wa_log.size();
    base_done = done_cnt;
    base_rst  = rst_cnt;
  endtask

  // Checks the writes produced by a frame whose payload is f[2 .. size-2].
  task automatic check_writes(input string tag, input logic [7:0] f[$]);
    int n;
    n = f.size() - 3;
    chk({tag, "_wr_count"}, wa_log.size() - base_wr, n);
    for (int i = 0; i < n && (base_wr + i) < wa_log.size(); i++) begin
      chk({tag, "_addr"}, {28'd0, wa_log[base_wr+i]}, i);
      chk({tag, "_data"}, {24'd0, wd_log[base_wr+i]}, {24'd0, f[i+2]});
    end
  endtask

  task automatic check_good(input string tag, input int nbytes);
    chk({tag, "_done"}, done_cnt - base_done, 1);
    chk({tag, "_cpu_rst"}, rst_cnt - base_rst, 1);
    chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 0);
    chk({tag, "_load_err"}, {31'd0, load_err}, 0);
    chk({tag, "_bytes"}, {27'd0, bytes_loaded}, nbytes);
  endtask

  task automatic check_bad(input string tag, input int nwr, input int nbytes);
    chk({tag, "_wr_count"}, wa_log.size() - base_wr, nwr);
    chk({tag, "_done"}, done_cnt - base_done, 0);
    chk({tag, "_cpu_rst"}, rst_cnt - base_rst, 0);
    chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 1);
    chk({tag, "_load_err"}, {31'd0, load_err}, 1);
    chk({tag, "_bytes"}, {27'd0, bytes_loaded}, nbytes);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 1);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 0);
    chk({tag, "_mem_addr"}, {28'd0, mem_addr}, 0);
    chk({tag, "_mem_wdata"}, {24'd0, mem_wdata}, 0);
    chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 1);
    chk({tag, "_cpu_rst"}, {31'd0, cpu_rst}, 0);
    chk({tag, "_load_done"}, {31'd0, load_done}, 0);
    chk({tag, "_load_err"}, {31'd0, load_err}, 0);
    chk({tag, "_bytes"}, {27'd0, bytes_loaded}, 0);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #1;
    check_reset_vals("por");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Full 16-byte image at full rate
    fr = '{8'hA5, 8'h10, 8'hE0, 8'h29, 8'h8A, 8'h4B, 8'h6C, 8'h8D, 8'hCE, 8'hA0,
           8'h00, 8'h0C, 8'h05, 8'h04, 8'h09, 8'h03, 8'h09, 8'h07, 8'h76};
    mark();
    send_frame(fr, 1'b0);
    go_idle(2);
    check_writes("good16", fr);
    check_good("good16", 16);

    // Bad checksum: 11+22 = 33, frame carries 00
    fr = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h00};
    mark();
    send_frame(fr, 1'b0);
    go_idle(2);
    check_writes("badcs", fr);
    check_bad("badcs", 2, 2);

    fr = '{8'hA5, 8'h01, 8'h5A, 8'h5A};
    mark();
    send_frame(fr, 1'b0);
    go_idle(2);
    check_writes("recover", fr);
    check_good("recover", 1);

    // Illegal lengths
    fr = '{8'hA5, 8'h00};
    mark();
    send_frame(fr, 1'b0);
    go_idle(2);
    check_bad("len0", 0, 0);

    fr = '{8'hA5, 8'h11};
    mark();
    send_frame(fr, 1'b0);
    go_idle(2);
    check_bad("len17", 0, 0);

    // Junk before the frame, SYNC value inside the payload
    fr = '{8'h00, 8'hFF, 8'h3C};
    mark();
    send_frame(fr, 1'b0);
    fr = '{8'hA5, 8'h02, 8'hA5, 8'h01, 8'hA6};
    send_frame(fr, 1'b0);
    go_idle(2);
    check_writes("insync", fr);
    check_good("insync", 2);

    // Reset after three data bytes of a 16-byte frame
    fr = '{8'hA5, 8'h10, 8'h01, 8'h02, 8'h03};
    mark();
    send_frame(fr, 1'b0);
    #1;
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_done", done_cnt - base_done, 0);
    chk("midrst_hold", {31'd0, cpu_hold}, 1);

    fr = '{8'hA5, 8'h10, 8'hE0, 8'h29, 8'h8A, 8'h4B, 8'h6C, 8'h8D, 8'hCE, 8'hA0,
           8'h00, 8'h0C, 8'h05, 8'h04, 8'h09, 8'h03, 8'h09, 8'h07, 8'h76};
    mark();
    send_frame(fr, 1'b0);
    go_idle(2);
    check_writes("afterrst", fr);
    check_good("afterrst", 16);

    // Random gaps, then a byte presented during the DONE cycle
    fr = '{8'hA5, 8'h04, 8'h10, 8'h20, 8'h30, 8'hF5, 8'h55};
    mark();
    send_frame(fr, 1'b1);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hA5;
    chk("done_in_ready", {31'd0, in_ready}, 0);
    chk("done_load_done", {31'd0, load_done}, 1);
    chk("done_cpu_rst", {31'd0, cpu_rst}, 1);
    @(negedge clk);
    chk("held_in_ready", {31'd0, in_ready}, 1);
    chk("held_cpu_hold", {31'd0, cpu_hold}, 0);
    chk("held_load_done", {31'd0, load_done}, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("resync_cpu_hold", {31'd0, cpu_hold}, 1);
    check_writes("gaps", fr);
    chk("gaps_done", done_cnt - base_done, 1);
    chk("gaps_err", {31'd0, load_err}, 0);

    fr = '{8'h02, 8'h12, 8'h34, 8'h46};
    mark();
    send_frame(fr, 1'b1);
    go_idle(2);
    chk("tail_wr_count", wa_log.size() - base_wr, 2);
    check_good("tail", 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
